// File: rtl/conv_stream_sink.sv
// rtl/conv_stream_sink.sv - framed sample sink with count, checksum, timeout and overrun flags
// Optional feature macro: CONV_SINK_CHECKSUM_EN enables the running checksum.
module conv_stream_sink #(
  parameter int DATA_SIZE      = 16,
  parameter int DATA_CYCLES    = 40,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 in_ready,
  output logic [15:0]          sample_count,
  output logic [31:0]          checksum,
  output logic                 done,
  output logic                 error_timeout,
  output logic                 error_overrun
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [1:0] S_ERROR   = 2'd3;

  localparam logic [15:0] LAST_COUNT = 16'(DATA_CYCLES);
  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [1:0]  state;
  logic [15:0] idle_count;
  logic        transfer;
  logic        open_frame;

  assign transfer   = in_valid & in_ready;
  assign open_frame = start & (state != S_COLLECT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      in_ready      <= 1'b0;
      sample_count  <= 16'd0;
      idle_count    <= 16'd0;
      done          <= 1'b0;
      error_timeout <= 1'b0;
      error_overrun <= 1'b0;
    end else if (open_frame) begin
      // start outranks a coincident in_valid in DONE, so no overrun is flagged
      state         <= S_COLLECT;
      in_ready      <= 1'b1;
      sample_count  <= 16'd0;
      idle_count    <= 16'd0;
      done          <= 1'b0;
      error_timeout <= 1'b0;
      error_overrun <= 1'b0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (transfer) begin
            sample_count <= sample_count + 16'd1;
            idle_count   <= 16'd0;
            if (sample_count + 16'd1 == LAST_COUNT) begin
              state    <= S_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end else begin
            idle_count <= idle_count + 16'd1;
            if (idle_count + 16'd1 == IDLE_LIMIT) begin
              state         <= S_ERROR;
              in_ready      <= 1'b0;
              error_timeout <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (in_valid) error_overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CONV_SINK_CHECKSUM_EN
  logic signed [31:0] sample_ext;
  assign sample_ext = 32'(signed'(in_data));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= 32'd0;
    end else if (open_frame) begin
      checksum <= 32'd0;
    end else if (state == S_COLLECT && transfer) begin
      checksum <= checksum + sample_ext;
    end
  end
`else
  logic unused_data;
  assign unused_data = ^in_data;
  assign checksum    = 32'd0;
`endif

endmodule

// File: tb/tb_conv_stream_sink.sv
// tb/tb_conv_stream_sink.sv - directed self-checking bench for conv_stream_sink
module tb_conv_stream_sink;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] sample_count;
  logic [31:0] checksum;
  logic        done;
  logic        error_timeout;
  logic        error_overrun;

  int pass_count;
  int check_count;

`ifdef CONV_SINK_CHECKSUM_EN
  localparam logic [31:0] RAMP_SUM = 32'd820;
  localparam logic [31:0] NEG_SUM  = 32'hFFFF_FFD8;
  localparam logic [31:0] SUM_30   = 32'd30;
`else
  localparam logic [31:0] RAMP_SUM = 32'd0;
  localparam logic [31:0] NEG_SUM  = 32'd0;
  localparam logic [31:0] SUM_30   = 32'd0;
`endif

  conv_stream_sink dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .sample_count (sample_count),
    .checksum     (checksum),
    .done         (done),
    .error_timeout(error_timeout),
    .error_overrun(error_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ramp=1 sends first, first+1, ...; ramp=0 repeats first
  task automatic send_samples(input int n, input logic [15:0] first, input bit ramp);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = ramp ? first + 16'(i) : first;
      tick();
    end
    in_valid = 1'b0;
    in_data  = 16'd0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    check_count++;
    if ({in_ready, done, error_timeout, error_overrun} !== 4'b0000 ||
        sample_count !== 16'd0 || checksum !== 32'd0)
      $display("FAIL reset_state: ready=%b done=%b tmo=%b ovr=%b count=%0d sum=%h, required all 0",
               in_ready, done, error_timeout, error_overrun, sample_count, checksum);
    else pass_count++;
    reset_n = 1'b1;
    idle_cycles(3);
    check_count++;
    if (in_ready !== 1'b0 || done !== 1'b0)
      $display("FAIL idle_wait: ready=%b done=%b, required 0 0", in_ready, done);
    else pass_count++;
  endtask

  task automatic test_ramp_frame();
    start_frame();
    check_count++;
    if (in_ready !== 1'b1)
      $display("FAIL collect_ready: ready=%b, required 1", in_ready);
    else pass_count++;
    send_samples(19, 16'd1, 1'b1);
    // a start inside the frame must be ignored
    start = 1'b1;
    send_samples(1, 16'd20, 1'b1);
    start = 1'b0;
    check_count++;
    if (sample_count !== 16'd20)
      $display("FAIL start_ignored: count=%0d, required 20", sample_count);
    else pass_count++;
    send_samples(19, 16'd21, 1'b1);
    check_count++;
    if (done !== 1'b0 || sample_count !== 16'd39)
      $display("FAIL before_last: done=%b count=%0d, required 0 39", done, sample_count);
    else pass_count++;
    send_samples(1, 16'd40, 1'b1);
    check_count++;
    if (done !== 1'b1 || sample_count !== 16'd40 || checksum !== RAMP_SUM || in_ready !== 1'b0)
      $display("FAIL ramp_done: done=%b count=%0d sum=%h ready=%b, required 1 40 %h 0",
               done, sample_count, checksum, in_ready, RAMP_SUM);
    else pass_count++;
  endtask

  task automatic test_negative_frame();
    start_frame();
    check_count++;
    if (done !== 1'b0 || sample_count !== 16'd0 || checksum !== 32'd0)
      $display("FAIL restart_clear: done=%b count=%0d sum=%h, required 0 0 0",
               done, sample_count, checksum);
    else pass_count++;
    send_samples(40, 16'hFFFF, 1'b0);
    check_count++;
    if (done !== 1'b1 || checksum !== NEG_SUM || error_overrun !== 1'b0)
      $display("FAIL negative_sum: done=%b sum=%h ovr=%b, required 1 %h 0",
               done, checksum, error_overrun, NEG_SUM);
    else pass_count++;
  endtask

  task automatic test_timeout_gap();
    start_frame();
    send_samples(10, 16'd1, 1'b0);
    idle_cycles(63);
    check_count++;
    if (error_timeout !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL gap63_alive: tmo=%b ready=%b, required 0 1", error_timeout, in_ready);
    else pass_count++;
    send_samples(30, 16'd1, 1'b0);
    check_count++;
    if (done !== 1'b1 || error_timeout !== 1'b0 || sample_count !== 16'd40)
      $display("FAIL gap63_done: done=%b tmo=%b count=%0d, required 1 0 40",
               done, error_timeout, sample_count);
    else pass_count++;

    start_frame();
    send_samples(10, 16'd3, 1'b0);
    idle_cycles(63);
    check_count++;
    if (error_timeout !== 1'b0)
      $display("FAIL gap64_early: tmo=%b after 63 idle, required 0", error_timeout);
    else pass_count++;
    idle_cycles(1);
    check_count++;
    if (error_timeout !== 1'b1 || sample_count !== 16'd10 || in_ready !== 1'b0 || done !== 1'b0)
      $display("FAIL gap64_timeout: tmo=%b count=%0d ready=%b done=%b, required 1 10 0 0",
               error_timeout, sample_count, in_ready, done);
    else pass_count++;
    send_samples(30, 16'd1, 1'b0);
    check_count++;
    if (error_timeout !== 1'b1 || sample_count !== 16'd10 || checksum !== SUM_30 || done !== 1'b0)
      $display("FAIL error_hold: tmo=%b count=%0d sum=%h done=%b, required 1 10 %h 0",
               error_timeout, sample_count, checksum, done, SUM_30);
    else pass_count++;
  endtask

  task automatic test_overrun();
    start_frame();
    check_count++;
    if (error_timeout !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL error_restart: tmo=%b ready=%b, required 0 1", error_timeout, in_ready);
    else pass_count++;
    send_samples(40, 16'd1, 1'b1);
    send_samples(3, 16'd7, 1'b0);
    check_count++;
    if (error_overrun !== 1'b1 || sample_count !== 16'd40 || done !== 1'b1 || checksum !== RAMP_SUM)
      $display("FAIL overrun_set: ovr=%b count=%0d done=%b sum=%h, required 1 40 1 %h",
               error_overrun, sample_count, done, checksum, RAMP_SUM);
    else pass_count++;
    idle_cycles(2);
    check_count++;
    if (error_overrun !== 1'b1 || done !== 1'b1)
      $display("FAIL overrun_sticky: ovr=%b done=%b, required 1 1", error_overrun, done);
    else pass_count++;
    start_frame();
    check_count++;
    if (done !== 1'b0 || error_overrun !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL overrun_clear: done=%b ovr=%b ready=%b, required 0 0 1",
               done, error_overrun, in_ready);
    else pass_count++;
    send_samples(40, 16'd1, 1'b1);
    // start and in_valid together in DONE: start wins
    start    = 1'b1;
    in_valid = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check_count++;
    if (error_overrun !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1 || sample_count !== 16'd0)
      $display("FAIL start_wins: ovr=%b done=%b ready=%b count=%0d, required 0 0 1 0",
               error_overrun, done, in_ready, sample_count);
    else pass_count++;
  endtask

  task automatic test_async_reset();
    send_samples(20, 16'd5, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_count++;
    if ({in_ready, done, error_timeout, error_overrun} !== 4'b0000 ||
        sample_count !== 16'd0 || checksum !== 32'd0)
      $display("FAIL async_reset: ready=%b done=%b tmo=%b ovr=%b count=%0d sum=%h, required all 0",
               in_ready, done, error_timeout, error_overrun, sample_count, checksum);
    else pass_count++;
    tick();
    reset_n = 1'b1;
    tick();
    start_frame();
    send_samples(40, 16'd1, 1'b1);
    check_count++;
    if (done !== 1'b1 || sample_count !== 16'd40 || checksum !== RAMP_SUM || error_timeout !== 1'b0)
      $display("FAIL post_reset_frame: done=%b count=%0d sum=%h tmo=%b, required 1 40 %h 0",
               done, sample_count, checksum, error_timeout, RAMP_SUM);
    else pass_count++;
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 16'd0;
    test_reset();
    test_ramp_frame();
    test_negative_frame();
    test_timeout_gap();
    test_overrun();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
